// File: rtl/cpu_boot_loader.sv
// Boot loader in front of the cpu: streams a header plus program/data words into the cpu memories,
// runs the cpu for a cycle budget, then dumps data memory. Optional load checksum: BOOT_CHECKSUM_EN.
module cpu_boot_loader #(
    parameter int IMEM_DEPTH = 512,
    parameter int DMEM_DEPTH = 1024,
    parameter int ADDR_STEP  = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [31:0] run_cycles,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        cpu_enable,
    output logic [31:0] addr_ext,
    output logic [31:0] wdata_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] addr_ext_2,
    output logic [31:0] wdata_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    input  logic [31:0] rdata_ext_2,
    output logic        busy,
    output logic        done,
    output logic        err
);
    typedef enum logic [3:0] {
        IDLE, HDR, LD_I, LD_D, CHK, RUN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif
    localparam logic [31:0] STEP = ADDR_STEP[31:0];

    state_t      state_q, state_d;
    logic [15:0] icnt_q, icnt_d, dcnt_q, dcnt_d, idx_q, idx_d;
    logic [31:0] run_left_q, run_left_d, run_cycles_q, run_cycles_d;
    logic        err_q, err_d, in_ready_q, in_ready_d, cpu_enable_q, cpu_enable_d;
    logic        wen_ext_q, wen_ext_d, wen_ext_2_q, wen_ext_2_d, ren_ext_2_q, ren_ext_2_d;
    logic [31:0] addr_ext_q, addr_ext_d, wdata_ext_q, wdata_ext_d;
    logic [31:0] addr_ext_2_q, addr_ext_2_d, wdata_ext_2_q, wdata_ext_2_d;
    logic        out_valid_q, out_valid_d, out_last_q, out_last_d, busy_q, busy_d, done_q, done_d;
    logic [31:0] out_data_q, out_data_d;
    logic        in_hs;
`ifdef BOOT_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    function automatic logic [31:0] word_addr(input logic [15:0] idx);
        return 32'(idx) * STEP;
    endfunction

    function automatic state_t dump_or_done(input logic [15:0] dc);
        return (dc != 16'd0) ? DUMP_RD : DONE;
    endfunction

    function automatic state_t run_or_dump(input logic [15:0] dc, input logic [31:0] rc);
        return (rc != 32'd0) ? RUN : dump_or_done(dc);
    endfunction

    function automatic state_t after_load(input logic [15:0] dc, input logic [31:0] rc);
        return CHK_EN ? CHK : run_or_dump(dc, rc);
    endfunction

    always_comb begin
        state_d       = state_q;
        icnt_d        = icnt_q;
        dcnt_d        = dcnt_q;
        idx_d         = idx_q;
        run_left_d    = run_left_q;
        run_cycles_d  = run_cycles_q;
        err_d         = err_q;
        wen_ext_d     = 1'b0;
        wen_ext_2_d   = 1'b0;
        addr_ext_d    = addr_ext_q;
        wdata_ext_d   = wdata_ext_q;
        addr_ext_2_d  = addr_ext_2_q;
        wdata_ext_2_d = wdata_ext_2_q;
        out_data_d    = out_data_q;
        in_hs         = in_valid && in_ready_q;
`ifdef BOOT_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d      = HDR;
                err_d        = 1'b0;
                run_cycles_d = run_cycles;
            end
            HDR: if (in_hs) begin
                icnt_d = in_data[31:16];
                dcnt_d = in_data[15:0];
                idx_d  = 16'd0;
                if (32'(in_data[31:16]) > IMEM_DEPTH[31:0] || 32'(in_data[15:0]) > DMEM_DEPTH[31:0]) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else if (in_data[31:16] != 16'd0) begin
                    state_d = LD_I;
                end else if (in_data[15:0] != 16'd0) begin
                    state_d = LD_D;
                end else begin
                    state_d = after_load(in_data[15:0], run_cycles_q);
                end
            end
            LD_I: if (in_hs) begin
                wen_ext_d   = 1'b1;
                addr_ext_d  = word_addr(idx_q);
                wdata_ext_d = in_data;
                if (idx_q + 16'd1 == icnt_q) begin
                    idx_d   = 16'd0;
                    state_d = (dcnt_q != 16'd0) ? LD_D : after_load(dcnt_q, run_cycles_q);
                end else begin
                    idx_d = idx_q + 16'd1;
                end
            end
            LD_D: if (in_hs) begin
                wen_ext_2_d   = 1'b1;
                addr_ext_2_d  = word_addr(idx_q);
                wdata_ext_2_d = in_data;
                if (idx_q + 16'd1 == dcnt_q) begin
                    idx_d   = 16'd0;
                    state_d = after_load(dcnt_q, run_cycles_q);
                end else begin
                    idx_d = idx_q + 16'd1;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            CHK: if (in_hs) begin
                if (in_data != sum_q) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = run_or_dump(dcnt_q, run_cycles_q);
                end
            end
`endif
            // Down-counter holds the cycles left including the current one; it never wraps.
            RUN: if (run_left_q <= 32'd1) begin
                run_left_d = 32'd0;
                state_d    = dump_or_done(dcnt_q);
            end else begin
                run_left_d = run_left_q - 32'd1;
            end
            DUMP_RD:  state_d = DUMP_CAP;
            DUMP_CAP: begin
                out_data_d = rdata_ext_2;
                state_d    = DUMP_OUT;
            end
            DUMP_OUT: if (out_ready) begin
                if (idx_q + 16'd1 == dcnt_q) begin
                    idx_d   = 16'd0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    state_d = DUMP_RD;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef BOOT_CHECKSUM_EN
        if (in_hs && state_q inside {HDR, LD_I, LD_D}) sum_d = sum_q + in_data;
        if (start && state_q inside {IDLE, DONE}) sum_d = 32'd0;
`endif
        if (state_d == RUN && state_q != RUN) run_left_d = run_cycles_q;
        if (state_d == DUMP_RD) addr_ext_2_d = word_addr(idx_d);

        // Status outputs are decoded from the next state so they register in step with it.
        ren_ext_2_d  = (state_d == DUMP_RD);
        in_ready_d   = state_d inside {HDR, LD_I, LD_D, CHK};
        cpu_enable_d = (state_d == RUN);
        out_valid_d  = (state_d == DUMP_OUT);
        out_last_d   = out_valid_d && (idx_d + 16'd1 == dcnt_q);
        busy_d       = !(state_d inside {IDLE, DONE});
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q       <= IDLE;
            icnt_q        <= '0;
            dcnt_q        <= '0;
            idx_q         <= '0;
            run_left_q    <= '0;
            run_cycles_q  <= '0;
            err_q         <= 1'b0;
            in_ready_q    <= 1'b0;
            cpu_enable_q  <= 1'b0;
            wen_ext_q     <= 1'b0;
            wen_ext_2_q   <= 1'b0;
            ren_ext_2_q   <= 1'b0;
            addr_ext_q    <= '0;
            wdata_ext_q   <= '0;
            addr_ext_2_q  <= '0;
            wdata_ext_2_q <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            icnt_q        <= icnt_d;
            dcnt_q        <= dcnt_d;
            idx_q         <= idx_d;
            run_left_q    <= run_left_d;
            run_cycles_q  <= run_cycles_d;
            err_q         <= err_d;
            in_ready_q    <= in_ready_d;
            cpu_enable_q  <= cpu_enable_d;
            wen_ext_q     <= wen_ext_d;
            wen_ext_2_q   <= wen_ext_2_d;
            ren_ext_2_q   <= ren_ext_2_d;
            addr_ext_q    <= addr_ext_d;
            wdata_ext_q   <= wdata_ext_d;
            addr_ext_2_q  <= addr_ext_2_d;
            wdata_ext_2_q <= wdata_ext_2_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_data_q    <= out_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q         <= sum_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign cpu_enable  = cpu_enable_q;
    assign addr_ext    = addr_ext_q;
    assign wdata_ext   = wdata_ext_q;
    assign wen_ext     = wen_ext_q;
    assign ren_ext     = 1'b0;
    assign addr_ext_2  = addr_ext_2_q;
    assign wdata_ext_2 = wdata_ext_2_q;
    assign wen_ext_2   = wen_ext_2_q;
    assign ren_ext_2   = ren_ext_2_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule

// File: tb/tb_cpu_boot_loader.sv
// Directed bench for cpu_boot_loader: write/dump scoreboards fed from the stimulus, data memory model.
`timescale 1ns/1ps
module tb_cpu_boot_loader;
    logic        clk = 1'b0, arst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] run_cycles = 32'd0, in_data = 32'd0, rdata_ext_2;
    logic        in_ready, out_valid, out_last, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic        busy, done, err;
    logic [31:0] out_data, addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic [10:0] ctrl;

    always #5 clk = ~clk;

    cpu_boot_loader dut (
        .clk(clk), .arst_n(arst_n), .start(start), .run_cycles(run_cycles),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wdata_ext(wdata_ext), .wen_ext(wen_ext),
        .ren_ext(ren_ext), .addr_ext_2(addr_ext_2), .wdata_ext_2(wdata_ext_2), .wen_ext_2(wen_ext_2),
        .ren_ext_2(ren_ext_2), .rdata_ext_2(rdata_ext_2), .busy(busy), .done(done), .err(err)
    );

    assign ctrl = {in_ready, out_valid, out_last, cpu_enable, wen_ext, ren_ext,
                   wen_ext_2, ren_ext_2, busy, done, err};

    // Data memory model with one-cycle read latency.
    logic [31:0] dmem [0:1023];
    always @(posedge clk) begin
        if (wen_ext_2) dmem[addr_ext_2[11:2]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[11:2]];
    end

    int checks = 0, errors = 0;
    int n_wi = 0, n_wd = 0, n_en = 0, n_ren = 0, n_out = 0;
    logic [63:0] qi[$], qd[$], qo[$];
    logic [31:0] iw [0:7];
    logic [31:0] dw [0:7];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor: pops scoreboards on write strobes and dump handshakes.
    logic        stalled = 1'b0;
    logic [32:0] stall_word = '0;
    always @(negedge clk) begin
        logic [63:0] e;
        if (wen_ext) begin
            n_wi++;
            if (qi.size() != 0) begin e = qi.pop_front(); chk("imem_write", {addr_ext, wdata_ext}, e); end
        end
        if (wen_ext_2) begin
            n_wd++;
            if (qd.size() != 0) begin e = qd.pop_front(); chk("dmem_write", {addr_ext_2, wdata_ext_2}, e); end
        end
        if (cpu_enable) n_en++;
        if (ren_ext_2) begin
            chk("dump_rd_addr", {32'd0, addr_ext_2}, 64'(n_ren * 4));
            n_ren++;
        end
        if (stalled) chk("out_stable", {31'd0, out_last, out_data}, {31'd0, stall_word});
        stalled    = out_valid && !out_ready;
        stall_word = {out_last, out_data};
        if (out_valid && out_ready) begin
            n_out++;
            if (qo.size() != 0) begin e = qo.pop_front(); chk("dump_word", {31'd0, out_last, out_data}, e); end
        end
    end

    task automatic send(input logic [31:0] w, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) chk("send_ready_timeout", {63'd0, in_ready}, 64'd1);
        else begin @(posedge clk); #1; end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] rc);
        n_wi = 0; n_wd = 0; n_en = 0; n_ren = 0; n_out = 0;
        run_cycles = rc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic session(input logic [31:0] hdr, input logic [31:0] rc, input int gap,
                           input bit stall, input logic [31:0] cks_adj, input bit exp_err,
                           input int exp_en, input string tag);
        int ic, dc, n;
        bit ovf;
        logic [31:0] sum;
        ic  = int'(hdr[31:16]);
        dc  = int'(hdr[15:0]);
        ovf = (ic > 512) || (dc > 1024);
        out_ready = !stall;
        pulse_start(rc);
        send(hdr, gap);
        sum = hdr;
        if (!ovf) begin
            for (int k = 0; k < ic; k++) begin
                qi.push_back({32'(k * 4), iw[k]});
                send(iw[k], gap);
                sum += iw[k];
            end
            for (int k = 0; k < dc; k++) begin
                qd.push_back({32'(k * 4), dw[k]});
                if (!exp_err) qo.push_back({31'd0, 1'(k == dc - 1), dw[k]});
                send(dw[k], gap);
                sum += dw[k];
            end
`ifdef BOOT_CHECKSUM_EN
            send(sum + cks_adj, gap);
`endif
        end
        if (stall) begin
            n = 0;
            while (!out_valid && n < 200) begin @(negedge clk); n++; end
            @(posedge clk); #1;
            repeat (5) begin @(posedge clk); #1; end
            out_ready = 1'b1;
        end
        n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
        chk({tag, "_cpu_en_cycles"}, 64'(n_en), 64'(exp_en));
        chk({tag, "_imem_writes"}, 64'(n_wi), ovf ? 64'd0 : 64'(ic));
        chk({tag, "_dmem_writes"}, 64'(n_wd), ovf ? 64'd0 : 64'(dc));
        chk({tag, "_dump_words"}, 64'(n_out), (ovf || exp_err) ? 64'd0 : 64'(dc));
        chk({tag, "_sb_left"}, 64'(qi.size() + qd.size() + qo.size()), 64'd0);
        qi.delete(); qd.delete(); qo.delete();
        out_ready = 1'b1;
    endtask

    initial begin
        iw[0] = 32'hA; iw[1] = 32'hB; iw[2] = 32'hC;
        dw[0] = 32'h11; dw[1] = 32'h22;
        for (int k = 3; k < 8; k++) begin iw[k] = 32'h100 + k; dw[k] = 32'h200 + k; end

        // Reset held with start and in_valid active.
        in_valid = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {53'd0, ctrl}, 64'd0);
        chk("reset_addr", {addr_ext, addr_ext_2}, 64'd0);
        chk("reset_wdata", {wdata_ext, wdata_ext_2}, 64'd0);
        chk("reset_out_data", {32'd0, out_data}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        arst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_release", {53'd0, ctrl}, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        session(32'h0003_0002, 32'd10, 0, 1'b0, 32'd0, 1'b0, 10, "basic");
        session(32'h0003_0002, 32'd10, 2, 1'b1, 32'd0, 1'b0, 10, "gaps_stall");

        // Empty header with no run budget finishes right after the header.
        pulse_start(32'd0);
        send(32'h0000_0000, 0);
`ifdef BOOT_CHECKSUM_EN
        send(32'h0000_0000, 0);
`endif
        @(negedge clk);
        chk("empty_done_fast", {63'd0, done}, 64'd1);
        chk("empty_err", {63'd0, err}, 64'd0);
        chk("empty_no_strobes", 64'(n_wi + n_wd + n_ren + n_en), 64'd0);

        session(32'h0201_0000, 32'd10, 0, 1'b0, 32'd0, 1'b1, 0, "imem_ovf");
        session(32'h0000_0401, 32'd10, 0, 1'b0, 32'd0, 1'b1, 0, "dmem_ovf");
        session(32'h0000_0003, 32'd1, 0, 1'b0, 32'd0, 1'b0, 1, "dmem_only");
`ifdef BOOT_CHECKSUM_EN
        session(32'h0003_0002, 32'd10, 0, 1'b0, 32'd1, 1'b1, 0, "bad_checksum");
`endif

        // Reset mid-LD_I after one word.
        pulse_start(32'd4);
        send(32'h0003_0002, 0);
        qi.push_back({32'd0, iw[0]});
        send(iw[0], 0);
        @(negedge clk);
        #1 arst_n = 1'b0;
        #1;
        chk("abort_ctrl", {53'd0, ctrl}, 64'd0);
        chk("abort_addr", {addr_ext, addr_ext_2}, 64'd0);
        chk("abort_first_write", 64'(n_wi), 64'd1);
        qi.delete();
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        @(posedge clk); #1;
        session(32'h0003_0002, 32'd4, 0, 1'b0, 32'd0, 1'b0, 4, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule
